uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Unbuffered UART receiver: the far end of the uart_tx serial link. It
//  synchronises the incoming line, detects start bits and samples each bit at
//  mid-bit. It checks the stop bit, then presents each received word on a
//  one-entry valid/ready holding register to the consumer.
// PARAMETERS
//  CLOCKS_PER_BIT  4  clk cycles per bit; must match transmitter; legal >= 4
//  DATA_BITS       8  data bits per frame, LSB first; legal 5..9
// PORTS
//  clk        in   1          single clock; all logic on posedge
//  rst        in   1          reset, asynchronous, active-low (0 = reset)
//  rx         in   1          serial line, idle high, asynchronous to clk
//  data       out  DATA_BITS  received word, valid while valid=1
//  valid      out  1          holding register full
//  ready      in   1          consumer accepts word when valid && ready
//  frame_err  out  1          1-cycle pulse: stop bit sampled low
//  overrun    out  1          1-cycle pulse: word dropped, holding register full
//  parity_err out  1          1-cycle pulse: parity mismatch (tied 0 without macro)
// BEHAVIOUR
//  Reset (rst=0, immediate): data=0, valid=0, all error pulses 0, state IDLE,
//   synchroniser flops=1, counters=0. Reset mid-frame abandons the frame.
//  Input: 2-flop synchroniser rx -> rx_s; all decisions use rx_s only.
//  baud_cnt counts 0..CLOCKS_PER_BIT-1, cleared on every state entry.
//  FSM:
//   IDLE  : rx_s==0 -> START.
//   START : at baud_cnt==(CLOCKS_PER_BIT-1)/2 sample rx_s; 0 -> DATA,
//           1 -> IDLE (glitch rejected, nothing reported).
//   DATA  : baud_cnt==CLOCKS_PER_BIT-1 is mid-bit; shift rx_s into MSB of
//           shift reg (LSB first on line); after DATA_BITS samples -> PARITY
//           (macro) or STOP.
//   PARITY: one mid-bit sample; compare with even parity of shifted word.
//   STOP  : one mid-bit sample. 1 -> deliver, -> IDLE in same cycle so a start
//           bit following directly is caught. 0 -> frame_err, word dropped,
//           -> BREAK.
//   BREAK : wait for rx_s==1, then -> IDLE (no false start on held-low line).
//  Delivery: cycle after good stop sample: data<=word, valid<=1.
//  Handshake: valid clears the cycle after valid && ready; data holds while
//   valid=1 and !ready.
//  Simultaneous: delivery in same cycle as valid && ready -> new word loaded,
//   valid stays 1, no overrun. Delivery while valid && !ready -> overrun pulse,
//   new word dropped, old data kept.
//  Error pulses are mutually exclusive per frame; errored frames never set valid.
//  Latency: valid rises 1 cycle after stop mid-sample, ~DATA_BITS+1.5 bit times
//   +3 cycles after rx falls.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame = start, DATA_BITS, even parity bit, stop.
//   Mismatch -> parity_err pulse at stop sample, word dropped, -> IDLE (or BREAK
//   if stop also low; frame_err takes priority).
//  Not defined: no PARITY state, parity_err tied 0, frame = start+data+stop.
// TESTING  (CLOCKS_PER_BIT=4, DATA_BITS=8)
//  1 rst=0 mid-DATA, release, rx idle 100 cycles -> valid=0, data=0, no pulses.
//  2 uart_tx->uart_rx loopback, send 0xA5, ready=1 -> single valid cycle,
//    data=0xA5, frame_err=0.
//  3 rx low for 1 cycle only -> START rejects, back to IDLE, no valid,
//    no error pulse.
//  4 frame 0x3C with stop bit 0, then rx held 0 for 20 cycles, then 0x42
//    -> frame_err once; no valid for 0x3C; valid with data=0x42.
//  5 ready=0, back-to-back 0x11 then 0x22 -> data=0x11 held, overrun pulse at
//    0x22; ready=1 -> 0x11 consumed, valid=0.
//  6 (UART_RX_PARITY_EN) 0x07 with parity bit 0 -> parity_err pulse, no valid;
//    0x07 with parity bit 1 -> valid, data=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// Unbuffered UART receiver: 2-flop synchroniser, mid-bit sampling, stop check, one-entry valid/ready holding register.
// Latency: valid rises one cycle after the stop-bit mid sample (about DATA_BITS+1.5 bit times + 3 cycles after rx falls).
// Backpressure: no stall; a word that arrives while the holding register is full and not being taken is dropped with an overrun pulse.
// Optional even parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLOCKS_PER_BIT = 4,
  parameter int DATA_BITS      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 at_last;
  logic                 shift_en;
  logic                 stop_smp;
  logic                 word_ok;

  assign at_last = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    stop_smp  = 1'b0;
    case (state)
      S_IDLE:  if (!rx_s) state_nxt = S_START;
      // A start bit that is already high again at its centre was a glitch.
      S_START: if (baud_cnt == CNT_HALF) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (at_last) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (at_last) state_nxt = S_STOP;
`endif
      // Leave STOP on the sample itself so a directly following start bit is seen.
      S_STOP: begin
        if (at_last) begin
          stop_smp  = 1'b1;
          state_nxt = rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if ((state_nxt != state) || (state == S_IDLE) || (state == S_BREAK) || at_last)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      if (state != S_DATA) bit_cnt <= '0;
      else if (shift_en)   bit_cnt <= bit_cnt + 1'b1;

      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if ((state == S_PARITY) && at_last) par_bad <= (rx_s != ^shift_reg);
      // A low stop bit is reported as a framing error instead.
      parity_err <= stop_smp && rx_s && par_bad;
    end
  end

  assign word_ok = stop_smp && rx_s && !par_bad;
`else
  assign parity_err = 1'b0;
  assign word_ok    = stop_smp && rx_s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_smp && !rx_s;
      overrun   <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      // A consumer taking the old word this cycle frees the slot for the new one.
      if (word_ok) begin
        if (!valid || ready) begin
          data  <= shift_reg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
